// File: rtl/pwm_duty_ramp_pkg.sv
// Shared definitions for the duty-ramp sequencer: state encoding, duty width,
// PWM full-scale constant and saturating step helpers.
package pwm_duty_ramp_pkg;

   localparam int PWM_FULL_SCALE = 100;
   localparam int DUTY_W         = 7;

   typedef logic [DUTY_W-1:0] duty_t;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_TRACK      = 3'd1,
      ST_BR_UP      = 3'd2,
      ST_BR_HOLD_HI = 3'd3,
      ST_BR_DOWN    = 3'd4,
      ST_BR_HOLD_LO = 3'd5
   } state_e;

   // Both helpers work in 8 bits so cur+step and lim+step cannot wrap.
   function automatic duty_t step_up(duty_t cur, logic [7:0] step, duty_t lim);
      logic [7:0] sum;
      sum = 8'(cur) + step;
      return (sum >= 8'(lim)) ? lim : sum[DUTY_W-1:0];
   endfunction

   function automatic duty_t step_down(duty_t cur, logic [7:0] step, duty_t lim);
      logic [7:0] floor_v;
      logic [7:0] diff;
      floor_v = 8'(lim) + step;
      diff    = 8'(cur) - step;
      return (8'(cur) <= floor_v) ? lim : diff[DUTY_W-1:0];
   endfunction

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Control/status bundle between a controller and the duty-ramp sequencer.
interface pwm_duty_ramp_if;
   import pwm_duty_ramp_pkg::*;

   logic  en;
   logic  breathe;
   duty_t target;
   duty_t duty;
   logic  settled;
   logic  ramping;

   modport master (output en, breathe, target, input duty, settled, ramping);
   modport slave  (input en, breathe, target, output duty, settled, ramping);

endinterface

// File: rtl/pwm_duty_ramp_tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV enabled cycles, held
// at zero while disabled so the first tick is always a full period away.
module tick_prescaler #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (!en || tick) cnt_d = '0;
      else             cnt_d = cnt_q + CW'(1);
   end

   // NOTE: state updates use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle sequencer: slews duty toward a clamped target, or runs a
// triangle "breathing" profile with dwell at peak and floor.
module pwm_duty_ramp
   import pwm_duty_ramp_pkg::*;
#(
   parameter int TICK_DIV   = 1000,
   parameter int STEP       = 1,
   parameter int DUTY_MAX   = PWM_FULL_SCALE,
   parameter int HOLD_TICKS = 50
) (
   input logic              clk,
   input logic              rst_n,
   pwm_duty_ramp_if.slave   bus_io
);

   localparam logic [7:0]    STEP_B    = 8'(STEP);
   localparam duty_t         MAX_D     = duty_t'(DUTY_MAX);
   localparam int            HW        = $clog2(HOLD_TICKS + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

   state_e        state_q, state_d;
   duty_t         duty_q, duty_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          tick;
   logic          hold_done;
   duty_t         tgt_c, up_lim, dn_lim, up_v, dn_v;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus_io.en),
      .tick  (tick)
   );

   assign tgt_c     = (bus_io.target >= MAX_D) ? MAX_D : bus_io.target;
   assign up_lim    = (state_q == ST_TRACK) ? tgt_c : MAX_D;
   assign dn_lim    = (state_q == ST_TRACK) ? tgt_c : '0;
   assign up_v      = step_up(duty_q, STEP_B, up_lim);
   assign dn_v      = step_down(duty_q, STEP_B, dn_lim);
   assign hold_done = tick && (hold_q == HOLD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         duty_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         hold_q  <= hold_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      hold_d  = hold_q;
      if (!bus_io.en) begin
         state_d = ST_IDLE;
         duty_d  = '0;
         hold_d  = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               duty_d  = '0;
               state_d = bus_io.breathe ? ST_BR_UP : ST_TRACK;
            end
            ST_TRACK: begin
               if (bus_io.breathe)     state_d = ST_BR_UP;
               else if (tick) begin
                  if (duty_q < tgt_c)      duty_d = up_v;
                  else if (duty_q > tgt_c) duty_d = dn_v;
               end
            end
            ST_BR_UP: begin
               if (!bus_io.breathe) state_d = ST_TRACK;
               else if (tick) begin
                  duty_d = up_v;
                  if (up_v == MAX_D) begin
                     state_d = ST_BR_HOLD_HI;
                     hold_d  = '0;
                  end
               end
            end
            ST_BR_DOWN: begin
               if (!bus_io.breathe) state_d = ST_TRACK;
               else if (tick) begin
                  duty_d = dn_v;
                  if (dn_v == '0) begin
                     state_d = ST_BR_HOLD_LO;
                     hold_d  = '0;
                  end
               end
            end
            ST_BR_HOLD_HI, ST_BR_HOLD_LO: begin
               if (!bus_io.breathe) state_d = ST_TRACK;
               else if (hold_done)
                  state_d = (state_q == ST_BR_HOLD_HI) ? ST_BR_DOWN : ST_BR_UP;
               else if (tick)       hold_d = hold_q + HW'(1);
            end
            default: begin
               state_d = ST_IDLE;
               duty_d  = '0;
            end
         endcase
      end
   end

   always_comb begin
      bus_io.duty    = duty_q;
      bus_io.settled = 1'b0;
      bus_io.ramping = 1'b0;
      unique case (state_q)
         ST_TRACK: begin
            bus_io.settled = (duty_q == tgt_c);
            bus_io.ramping = (duty_q != tgt_c);
         end
         ST_BR_UP:   bus_io.ramping = (duty_q != MAX_D);
         ST_BR_DOWN: bus_io.ramping = (duty_q != '0);
         default:    ;
      endcase
   end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model of the profile.
module tb_pwm_duty_ramp;
   import pwm_duty_ramp_pkg::*;

   localparam int TICK_DIV = 4;
   localparam int STEP     = 10;
   localparam int DMAX     = 100;
   localparam int HOLD     = 2;

   localparam int M_OFF = 0, M_TRACK = 1, M_RISE = 2, M_TOP = 3, M_FALL = 4, M_BOTTOM = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   pwm_duty_ramp_if bus ();

   pwm_duty_ramp #(
      .TICK_DIV   (TICK_DIV),
      .STEP       (STEP),
      .DUTY_MAX   (DMAX),
      .HOLD_TICKS (HOLD)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural model: duty level, profile phase, enabled-cycle phase, dwell ticks.
   int m_duty  = 0;
   int m_mode  = M_OFF;
   int m_phase = 0;
   int m_dwell = 0;

   function automatic int clamp_t(int t);
      return (t > DMAX) ? DMAX : t;
   endfunction

   function automatic int approach(int cur, int dest);
      if (cur < dest) return (cur + STEP > dest) ? dest : cur + STEP;
      if (cur > dest) return (cur - STEP < dest) ? dest : cur - STEP;
      return cur;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_duty  = 0;
      m_mode  = M_OFF;
      m_phase = 0;
      m_dwell = 0;
   endtask

   task automatic model_step();
      bit tk;
      if (!rst_n) begin
         model_reset();
         return;
      end
      tk      = bus.en && (m_phase == TICK_DIV - 1);
      m_phase = !bus.en ? 0 : (m_phase + 1) % TICK_DIV;
      if (!bus.en) begin
         m_mode = M_OFF;
         m_duty = 0;
      end else if (m_mode == M_OFF) begin
         m_duty = 0;
         m_mode = bus.breathe ? M_RISE : M_TRACK;
      end else if (m_mode == M_TRACK) begin
         if (bus.breathe) m_mode = M_RISE;
         else if (tk)     m_duty = approach(m_duty, clamp_t(int'(bus.target)));
      end else if (!bus.breathe) begin
         m_mode = M_TRACK;
      end else if (tk) begin
         case (m_mode)
            M_RISE: begin
               m_duty = approach(m_duty, DMAX);
               if (m_duty == DMAX) begin m_mode = M_TOP; m_dwell = 0; end
            end
            M_FALL: begin
               m_duty = approach(m_duty, 0);
               if (m_duty == 0) begin m_mode = M_BOTTOM; m_dwell = 0; end
            end
            default: begin
               m_dwell++;
               if (m_dwell == HOLD) m_mode = (m_mode == M_TOP) ? M_FALL : M_RISE;
            end
         endcase
      end
   endtask

   task automatic compare(input string tag);
      int  tc;
      bit  exp_settled, exp_ramping;
      tc          = clamp_t(int'(bus.target));
      exp_settled = (m_mode == M_TRACK) && (m_duty == tc);
      exp_ramping = ((m_mode == M_TRACK) && (m_duty != tc)) ||
                    ((m_mode == M_RISE)  && (m_duty != DMAX)) ||
                    ((m_mode == M_FALL)  && (m_duty != 0));
      check({tag, ".duty"},    32'(bus.duty),    32'(m_duty));
      check({tag, ".settled"}, 32'(bus.settled), 32'(exp_settled));
      check({tag, ".ramping"}, 32'(bus.ramping), 32'(exp_ramping));
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare(tag);
   endtask

   task automatic run(input int n, input string tag);
      repeat (n) cycle(tag);
   endtask

   task automatic wait_duty(input int v, input int budget, input string tag);
      int k = 0;
      while (bus.duty !== 7'(v) && k < budget) begin
         cycle(tag);
         k++;
      end
      check({tag, ".reached"}, 32'(bus.duty), 32'(v));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.en      = 1'b0;
      bus.breathe = 1'b0;
      bus.target  = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("reset.duty",    32'(bus.duty),    32'd0);
      check("reset.settled", 32'(bus.settled), 32'd0);
      check("reset.ramping", 32'(bus.ramping), 32'd0);
      run(2, "idle");

      // Track up with clamp: first step exactly TICK_DIV edges after en.
      bus.en = 1'b1; bus.breathe = 1'b0; bus.target = 7'd127;
      run(3, "up_latency");
      check("up.pre_tick", 32'(bus.duty), 32'd0);
      run(1, "up_first");
      check("up.first_step", 32'(bus.duty), 32'd10);
      run(36, "up_ramp");
      check("up.top",     32'(bus.duty),    32'd100);
      check("up.settled", 32'(bus.settled), 32'd1);
      run(12, "up_hold");
      check("up.no_overshoot", 32'(bus.duty), 32'd100);

      // Track down to a non-multiple of STEP.
      bus.target = 7'd35;
      run(40, "down35");
      check("down.final",   32'(bus.duty),    32'd35);
      check("down.settled", 32'(bus.settled), 32'd1);

      // Target changed mid-ramp is honoured on the next tick.
      bus.target = 7'd100;
      run(60, "back_up");
      bus.target = 7'd35;
      run(16, "mid_ramp");
      check("mid.duty",    32'(bus.duty),    32'd60);
      check("mid.ramping", 32'(bus.ramping), 32'd1);
      bus.target = 7'd37;
      run(24, "retarget");
      check("retarget.final",   32'(bus.duty),    32'd37);
      check("retarget.settled", 32'(bus.settled), 32'd1);

      // Breathe from zero: 10 up, 2 hold, 10 down, 2 hold = 96 cycles.
      bus.en = 1'b0;
      cycle("pre_breathe");
      bus.en = 1'b1; bus.breathe = 1'b1;
      run(40, "br_up");
      check("br.peak", 32'(bus.duty), 32'd100);
      run(48, "br_down");
      check("br.floor", 32'(bus.duty), 32'd0);
      run(12, "br_restart");
      check("br.second_rise", 32'(bus.duty), 32'd10);
      run(36, "br_period");
      check("br.period_peak", 32'(bus.duty), 32'd100);

      // Breathe -> track keeps the current duty.
      bus.target = 7'd20;
      wait_duty(60, 100, "sw_wait");
      bus.breathe = 1'b0;
      cycle("sw_edge");
      check("sw.no_jump", 32'(bus.duty), 32'd60);
      run(20, "sw_track");
      check("sw.final",   32'(bus.duty),    32'd20);
      check("sw.settled", 32'(bus.settled), 32'd1);

      // Hard stop and restart with full prescaler delay.
      bus.target = 7'd100;
      wait_duty(70, 60, "dis_wait");
      bus.en = 1'b0;
      cycle("dis_edge");
      check("dis.zero", 32'(bus.duty), 32'd0);
      bus.en = 1'b1;
      run(3, "reen_latency");
      check("reen.pre_tick", 32'(bus.duty), 32'd0);
      run(1, "reen_first");
      check("reen.first_step", 32'(bus.duty), 32'd10);

      // Asynchronous reset mid-ramp, observed without a clock edge.
      wait_duty(40, 40, "rst_wait");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst.duty",    32'(bus.duty),    32'd0);
      check("arst.settled", 32'(bus.settled), 32'd0);
      check("arst.ramping", 32'(bus.ramping), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Random en/breathe/target activity against the model.
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 99) < 1) bus.en      = ~bus.en;
         if ($urandom_range(0, 99) < 2) bus.breathe = ~bus.breathe;
         if ($urandom_range(0, 99) < 5) bus.target  = 7'($urandom_range(0, 127));
         cycle("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Duty-cycle sequencer that sits directly upstream of the 0..100 PWM stage.
- Drives that stage's 7-bit duty input.
- Slews duty toward a requested target at a programmable rate (soft start/stop for LED/buzzer loads), or auto-generates a "breathing" triangle profile with dwell at peak and floor.
- Output is always clamped to 0..DUTY_MAX, so the downstream stage never has to saturate.

Parameters:
- TICK_DIV, 1000: clk cycles per ramp step tick (>=2).
- STEP, 1: duty change per tick (1..DUTY_MAX).
- DUTY_MAX, 100: maximum duty value issued.
- HOLD_TICKS, 50: ticks spent at peak and at floor in breathe mode (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  block enable; 0 forces idle
- breathe  in  1  1 = breathing profile, 0 = track target
- target  in  7  requested duty 0..127; values > DUTY_MAX treated as DUTY_MAX
- duty  out  7  registered duty to the PWM stage
- settled  out  1  high while in TRACK and duty == clamped target
- ramping  out  1  high in TRACK/BR_UP/BR_DOWN while duty is changing (duty != destination)

Behaviour:
- Reset (rst_n=0, async): state=IDLE, duty=0, prescaler=0, hold counter=0. settled=0, ramping=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while en=1.
  - tick is a 1-cycle internal pulse when the count equals TICK_DIV-1; the count then wraps to 0.
  - Held at 0 while en=0.
- Target clamp: tgt_c = (target >= DUTY_MAX) ? DUTY_MAX : target. Evaluated every cycle, so target may change at any time.
- Step arithmetic:
  - Done in 8 bits.
  - up = min(duty+STEP, limit).
  - down = (duty <= limit+STEP) ? limit : duty-STEP.
  - No wrap-around is permitted.
- States: IDLE, TRACK, BR_UP, BR_HOLD_HI, BR_DOWN, BR_HOLD_LO.
- IDLE:
  - duty is forced to 0 on the next clock edge.
  - When en=1, the next state is TRACK if breathe=0, else BR_UP.
- en=0 in any state: next edge goes to IDLE and duty=0 (hard stop, no ramp-down).
- TRACK: on tick, duty moves one step toward tgt_c (up or down, limited to tgt_c). There is no change when equal.
- BR_UP:
  - On tick, duty = up with limit DUTY_MAX.
  - When the stepped value equals DUTY_MAX, go to BR_HOLD_HI with hold counter=0.
- BR_HOLD_HI:
  - Hold counter increments on each tick.
  - After HOLD_TICKS ticks, go to BR_DOWN.
- BR_DOWN: on tick, duty = down with limit 0. When it reaches 0, go to BR_HOLD_LO.
- BR_HOLD_LO: same as HOLD_HI, then go to BR_UP.
- Mode change with en=1:
  - breathe 1->0 from any BR_* state goes to TRACK next edge, keeping the current duty (no jump).
  - breathe 0->1 from TRACK goes to BR_UP, keeping duty.
- Latency: the first duty change occurs TICK_DIV cycles after en rises (IDLE exit cycle + full prescaler period).
- settled and ramping are combinational decodes of registered state/duty and current tgt_c.
- duty is only ever one of: unchanged, one step, or 0.

Decomposition:
- Shared package holds:
  - state encoding localparams (3-bit: IDLE=0, TRACK=1, BR_UP=2, BR_HOLD_HI=3, BR_DOWN=4, BR_HOLD_LO=5);
  - PWM_FULL_SCALE=100, shared with the PWM stage.
- One natural sub-module: tick_prescaler (TICK_DIV parameter; clk, rst_n, en in; tick out), reusable by other timed blocks.
- FSM and step datapath stay in pwm_duty_ramp.

Test Plan (TICK_DIV=4, STEP=10, DUTY_MAX=100, HOLD_TICKS=2 unless noted):
- Reset mid-ramp: assert rst_n=0 while duty=40 in TRACK -> duty=0, settled=0 immediately, without waiting for clk.
- Track up with clamp: en=1, breathe=0, target=127 ->
  - duty 10,20,...,100, one step every 4 cycles (first step 4 cycles after en);
  - then holds at 100 with settled=1; never exceeds 100.
- Track down non-multiple: from duty=100, target=35 -> duty 90,80,...,40,35, then settled=1. Target changed to 37 mid-ramp is honoured on the next tick.
- Breathe cycle: breathe=1 from duty=0 ->
  - 10 ticks up to 100;
  - 2 ticks at 100;
  - 10 ticks down to 0;
  - 2 ticks at 0;
  - repeats. Period = 24 ticks = 96 cycles.
- Mode switch: breathe 1->0 at duty=60 with target=20 -> TRACK, duty 50,40,30,20, settled=1. No jump to 0.
- Disable: en=0 at duty=70 -> duty=0 next edge, state IDLE. Re-enable restarts with a full TICK_DIV delay before the first step.
